// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready handshake bundle for pipe_stage_reg.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_slot.sv
// One storage slot: valid flop, resettable low field (reset/clear to RST_VAL)
// and an unreset datapath remainder. Priority: clear > load > drop.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int          DATA_W  = 96,
  parameter int          RST_W   = 32,
  parameter logic [31:0] RST_VAL = NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic              drop,
  input  logic [DATA_W-1:0] d,
  output logic              vld,
  output logic [DATA_W-1:0] q
);

  logic vld_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   vld_p0 <= 1'b0;
    else if (clear) vld_p0 <= 1'b0;
    else if (load)  vld_p0 <= 1'b1;
    else if (drop)  vld_p0 <= 1'b0;
  end

  assign vld = vld_p0;

  if (RST_W > 0) begin : g_fld
    localparam logic [RST_W-1:0] FLD_RST = RST_W'(RST_VAL);
    logic [RST_W-1:0] fld_p0;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   fld_p0 <= FLD_RST;
      else if (clear) fld_p0 <= FLD_RST;
      else if (load)  fld_p0 <= d[RST_W-1:0];
    end

    assign q[RST_W-1:0] = fld_p0;
  end

  // Remainder keeps its old value across reset and flush.
  if (RST_W < DATA_W) begin : g_rem
    logic [DATA_W-1:RST_W] rem_p0;

    always_ff @(posedge clk) begin
      if (load && !clear) rem_p0 <= d[DATA_W-1:RST_W];
    end

    assign q[DATA_W-1:RST_W] = rem_p0;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with flush, halt and reset-to-NOP field.
// Define PIPE_SKID_EN for a two-slot skid buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W  = 96,
  parameter int          RST_W   = 32,
  parameter logic [31:0] RST_VAL = NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             halted,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output occ_t             occupancy
);

  logic              main_vld;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic              main_load;
  logic              main_drop;
  logic              in_xfer;
  logic              out_xfer;

  assign bus.out_valid = main_vld & ~halted;
  assign bus.out_data  = main_q;
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = bus.out_valid & bus.out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_vld;
  logic [DATA_W-1:0] skid_q;
  logic              skid_load;
  logic              skid_drop;
  logic              skid_vld_nxt;
  logic              rdy_p0;

  // Skid slot fills only when the main slot is held; it drains into main on output.
  assign skid_load = in_xfer & main_vld & ~out_xfer;
  assign skid_drop = out_xfer & skid_vld;
  assign main_load = skid_drop | (in_xfer & (~main_vld | out_xfer));
  assign main_d    = skid_vld ? skid_q : bus.in_data;
  assign main_drop = out_xfer & ~main_load;

  always_comb begin
    skid_vld_nxt = skid_vld;
    if (flush)          skid_vld_nxt = 1'b0;
    else if (skid_load) skid_vld_nxt = 1'b1;
    else if (skid_drop) skid_vld_nxt = 1'b0;
  end

  // in_ready comes straight from a flop: ready whenever the skid slot will be free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_p0 <= 1'b0;
    else          rdy_p0 <= ~skid_vld_nxt;
  end

  assign bus.in_ready = rdy_p0 & ~halted;
  assign occupancy    = {skid_vld, main_vld & ~skid_vld};

  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_W   (RST_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (flush),
    .drop    (skid_drop),
    .d       (bus.in_data),
    .vld     (skid_vld),
    .q       (skid_q)
  );
`else
  assign bus.in_ready = reset_n & ~halted & (~main_vld | bus.out_ready);
  assign main_load    = in_xfer;
  assign main_drop    = out_xfer & ~in_xfer;
  assign main_d       = bus.in_data;
  assign occupancy    = {1'b0, main_vld};
`endif

  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_W   (RST_W),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .clear   (flush),
    .drop    (main_drop),
    .d       (main_d),
    .vld     (main_vld),
    .q       (main_q)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios followed by random traffic.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W = 96;
  localparam int RST_W  = 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic halted  = 1'b0;
  logic flush   = 1'b0;
  occ_t occupancy;

  pipe_stage_reg_if #(.DATA_W(DATA_W)) bus ();

  pipe_stage_reg #(
    .DATA_W  (DATA_W),
    .RST_W   (RST_W),
    .RST_VAL (NOP_INSTR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .halted    (halted),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the stage is a FIFO of accepted payloads with capacity 1 (or 2 with skid).
  logic [DATA_W-1:0] exp_q[$];
  bit armed   = 1'b0;
  bit fld_nop = 1'b1;
  bit ir_exp  = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares control outputs against the model and pops on every output transfer.
  always @(negedge clk) begin
    int  n;
    bit  ov_exp;
    n = exp_q.size();
    if (!reset_n) begin
      ir_exp = 1'b0;
    end else begin
      ov_exp = (n > 0) && !halted;
`ifdef PIPE_SKID_EN
      ir_exp = !halted && armed && (n < 2);
`else
      ir_exp = !halted && ((n == 0) || bus.out_ready);
`endif
      check("out_valid", DATA_W'(bus.out_valid), DATA_W'(ov_exp));
      check("in_ready", DATA_W'(bus.in_ready), DATA_W'(ir_exp));
      check("occupancy", DATA_W'(occupancy), DATA_W'(n));
      if (fld_nop && !bus.out_valid)
        check("nop_field", DATA_W'(bus.out_data[RST_W-1:0]), DATA_W'(NOP_INSTR));
      if (bus.out_valid && bus.out_ready) begin
        if (n == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data: unexpected output %0h, none expected at %0t",
                   bus.out_data, $time);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
        end
      end
    end
  end

  // Drive one cycle of stimulus, then update the model for the coming clock edge.
  task automatic step(input bit iv, input logic [DATA_W-1:0] d, input bit ordy,
                      input bit fl, input bit hl);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    halted        = hl;
    @(negedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      fld_nop = 1'b1;
    end else if (iv && ir_exp) begin
      exp_q.push_back(d);
      fld_nop = 1'b0;
    end
    armed = 1'b1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", DATA_W'(bus.out_valid), '0);
    check("rst_in_ready", DATA_W'(bus.in_ready), '0);
    check("rst_occupancy", DATA_W'(occupancy), '0);
    check("rst_nop_field", DATA_W'(bus.out_data[RST_W-1:0]), DATA_W'(NOP_INSTR));
    exp_q.delete();
    fld_nop       = 1'b1;
    armed         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    halted        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    armed = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    apply_reset();
    idle(2);

    // Back-to-back stream with downstream always ready.
    step(1'b1, DATA_W'(32'h100), 1'b1, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'h104), 1'b1, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'h108), 1'b1, 1'b0, 1'b0);
    idle(2);

    // Downstream stall for three cycles mid-stream.
    step(1'b1, DATA_W'(32'h200), 1'b1, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'h204), 1'b0, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'h208), 1'b0, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'h20c), 1'b0, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'h210), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Flush in the same cycle as a new input.
    step(1'b1, DATA_W'(32'h300), 1'b0, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'hDEAD_BEEF), 1'b1, 1'b1, 1'b0);
    idle(3);

    // Halt while full, then release.
    step(1'b1, DATA_W'(32'h400), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Reset while the stage holds data.
    step(1'b1, DATA_W'(32'h500), 1'b0, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'h504), 1'b0, 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'h508), 1'b0, 1'b0, 1'b0);
    apply_reset();
    idle(2);

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0,
           {$urandom(), $urandom(), $urandom()},
           ($urandom % 3) != 0,
           ($urandom % 20) == 0,
           ($urandom % 12) == 0);
    end
    idle(4);
    check("drained", DATA_W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
